// File: rtl/digit_entry_pkg.sv
// -----------------------------------------------------------------------------
// digit_entry_pkg
//   Shared definitions for the four-digit BCD entry block:
//     NUM_DIGITS / BCD_MAX  - display geometry and BCD range
//     SEL_W                 - width of the cursor index
//     bcd_t                 - one BCD digit
//     action_t              - decoded user action, one per clock at most
//     bcd_inc / bcd_dec     - wrapping BCD step helpers
// -----------------------------------------------------------------------------
package digit_entry_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_MAX    = 9;
    localparam int SEL_W      = $clog2(NUM_DIGITS);

    typedef logic [3:0] bcd_t;

    typedef enum logic [2:0] {
        NONE,
        CLR,
        SEL,
        UP,
        DOWN
    } action_t;

    // Step up with 9 -> 0 wrap. Any out-of-range input also lands on 0, so a
    // digit register can never be pushed into 10..15.
    function automatic bcd_t bcd_inc(input bcd_t d);
        bcd_t r;
        if (d >= bcd_t'(BCD_MAX)) begin
            r = '0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // Step down with 0 -> 9 wrap; out-of-range input recovers to 9.
    function automatic bcd_t bcd_dec(input bcd_t d);
        bcd_t r;
        if ((d == 4'd0) || (d > bcd_t'(BCD_MAX))) begin
            r = bcd_t'(BCD_MAX);
        end else begin
            r = d - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_entry_debounce.sv
// -----------------------------------------------------------------------------
// debounce
//   Conditions one raw asynchronous push button into a single-cycle press
//   pulse.
//     clk      - system clock
//     rst      - asynchronous active-high reset
//     i_btn    - raw button level (asynchronous)
//     o_pulse  - one-cycle pulse on each accepted 0->1 transition
//
//   Pipeline: 2-flop synchronizer -> stability counter -> accepted level ->
//   registered rising-edge detect. A clean press that is raw-high from edge N
//   gives o_pulse high after edge N+DEBOUNCE_CYCLES+2.
//   DEBOUNCE_CYCLES must be at least 2.
// -----------------------------------------------------------------------------
module debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;

            // The counter only runs while the synchronized input disagrees
            // with the accepted level; any agreeing cycle restarts it, so a
            // glitch has to persist for the whole window to be accepted.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_cnt_inc == CNT_TARGET) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= w_cnt_inc;
            end

            r_level_d <= r_level;
            // Rising edge of the accepted level only: holds and releases
            // produce nothing.
            r_pulse   <= r_level & ~r_level_d;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/digit_entry.sv
// -----------------------------------------------------------------------------
// digit_entry
//   Four-digit BCD entry controller driven by four push buttons.
//     clk, rst                  - clock, asynchronous active-high reset
//     btn_up / btn_down         - step the selected digit (wrapping 0..9)
//     btn_sel                   - advance the cursor 0->1->2->3->0
//     btn_clr                   - zero all digits and the cursor
//     digit_1..digit_4          - BCD digits, digit_1 leftmost
//     sel                       - cursor index (0 = digit_1)
//     blink_mask                - one-hot cursor, bit0 = digit_1
//     changed                   - one-cycle pulse when new digit/sel
//                                 values first appear on the outputs
//
//   Every button is debounced into a press pulse. At most one action runs per
//   clock, chosen with priority clr > sel > up > down; losing pulses in the
//   same cycle are dropped. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       btn_clr,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic [3:0] digit_3,
    output logic [3:0] digit_4,
    output logic [1:0] sel,
    output logic [3:0] blink_mask,
    output logic       changed
);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_pulse_up;
    logic w_pulse_down;
    logic w_pulse_sel;
    logic w_pulse_clr;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_up),
        .o_pulse (w_pulse_up)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_down),
        .o_pulse (w_pulse_down)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_sel),
        .o_pulse (w_pulse_sel)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_clr),
        .o_pulse (w_pulse_clr)
    );

    // ------------------------------------------------------------------
    // Priority encoder
    // ------------------------------------------------------------------
    action_t w_action;

    always_comb begin
        w_action = NONE;
        if (w_pulse_clr) begin
            w_action = CLR;
        end else if (w_pulse_sel) begin
            w_action = SEL;
        end else if (w_pulse_up) begin
            w_action = UP;
        end else if (w_pulse_down) begin
            w_action = DOWN;
        end
    end

    // ------------------------------------------------------------------
    // Next-state for digits and cursor
    // ------------------------------------------------------------------
    bcd_t             r_digit [NUM_DIGITS];
    logic [SEL_W-1:0] r_sel;
    logic [3:0]       r_mask;
    logic             r_changed;

    bcd_t             w_digit_nxt [NUM_DIGITS];
    logic [SEL_W-1:0] w_sel_nxt;

    always_comb begin
        w_digit_nxt = r_digit;
        w_sel_nxt   = r_sel;
        unique case (w_action)
            CLR: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    w_digit_nxt[i] = '0;
                end
                w_sel_nxt = '0;
            end
            // Cursor is exactly log2(NUM_DIGITS) bits, so 3 -> 0 is the
            // natural overflow.
            SEL:  w_sel_nxt = r_sel + 1'b1;
            UP:   w_digit_nxt[r_sel] = bcd_inc(r_digit[r_sel]);
            DOWN: w_digit_nxt[r_sel] = bcd_dec(r_digit[r_sel]);
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= '0;
            end
            r_sel     <= '0;
            r_mask    <= 4'b0001;
            r_changed <= 1'b0;
        end else begin
            r_digit   <= w_digit_nxt;
            r_sel     <= w_sel_nxt;
            // Mask is loaded from the same next value as the cursor so the
            // two can never disagree on the outputs.
            r_mask    <= 4'b0001 << w_sel_nxt;
            // Every action alters something (up/down/sel always move a value)
            // and clr pulses even when everything is already zero.
            r_changed <= (w_action != NONE);
        end
    end

    assign digit_1    = r_digit[0];
    assign digit_2    = r_digit[1];
    assign digit_3    = r_digit[2];
    assign digit_4    = r_digit[3];
    assign sel        = r_sel;
    assign blink_mask = r_mask;
    assign changed    = r_changed;

endmodule

// File: tb/tb_digit_entry.sv
module tb_digit_entry;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_sel;
    logic       btn_clr;
    logic [3:0] digit_1;
    logic [3:0] digit_2;
    logic [3:0] digit_3;
    logic [3:0] digit_4;
    logic [1:0] sel;
    logic [3:0] blink_mask;
    logic       changed;

    digit_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_sel    (btn_sel),
        .btn_clr    (btn_clr),
        .digit_1    (digit_1),
        .digit_2    (digit_2),
        .digit_3    (digit_3),
        .digit_4    (digit_4),
        .sel        (sel),
        .blink_mask (blink_mask),
        .changed    (changed)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_bad = 0;
    int changed_cnt = 0;

    // changed is counted mid-cycle, so a pulse two cycles wide counts twice
    always @(negedge clk) begin
        if (changed === 1'b1) changed_cnt++;
    end

    logic [3:0] dig_out [4];
    assign dig_out[0] = digit_1;
    assign dig_out[1] = digit_2;
    assign dig_out[2] = digit_3;
    assign dig_out[3] = digit_4;

    // ---------------- reference model ----------------
    // Holds the user-visible state; buttons are bits {clr,sel,down,up}.
    int m_dig [4];
    int m_sel;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_sel = 0;
    endfunction

    function automatic void model_press(input logic [3:0] b);
        if (b[3]) model_reset();
        else if (b[2]) m_sel = (m_sel + 1) % 4;
        else if (b[0]) m_dig[m_sel] = (m_dig[m_sel] + 1) % 10;
        else if (b[1]) m_dig[m_sel] = (m_dig[m_sel] + 9) % 10;
    endfunction

    // ---------------- table ----------------
    typedef struct {
        logic [3:0] btns;
        int         exp_d1;
        int         exp_sel;
        logic [3:0] exp_mask;
    } vec_t;

    vec_t tbl [$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] b);
        btn_up   = b[0];
        btn_down = b[1];
        btn_sel  = b[2];
        btn_clr  = b[3];
    endtask

    task automatic press(input logic [3:0] b, input int hold);
        drive(b);
        repeat (hold) tick();
        drive(4'b0000);
        repeat (DB + 6) tick();
    endtask

    task automatic do_press(input logic [3:0] b);
        press(b, DB + 2);
        model_press(b);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s digit_%0d", tag, i + 1), 32'(dig_out[i]), m_dig[i]);
        check({tag, " sel"}, 32'(sel), m_sel);
        check({tag, " blink_mask"}, 32'(blink_mask), 32'(1) << m_sel);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        logic [3:0] b;
        int w;

        // Table: up x12, down x3, sel x5 starting from all-zero, sel=0
        for (int i = 1; i <= 12; i++) tbl.push_back('{4'b0001, i % 10, 0, 4'b0001});
        tbl.push_back('{4'b0010, 1, 0, 4'b0001});
        tbl.push_back('{4'b0010, 0, 0, 4'b0001});
        tbl.push_back('{4'b0010, 9, 0, 4'b0001});
        tbl.push_back('{4'b0100, 9, 1, 4'b0010});
        tbl.push_back('{4'b0100, 9, 2, 4'b0100});
        tbl.push_back('{4'b0100, 9, 3, 4'b1000});
        tbl.push_back('{4'b0100, 9, 0, 4'b0001});
        tbl.push_back('{4'b0100, 9, 1, 4'b0010});

        rst = 1'b0;
        drive(4'b0000);
        model_reset();
        #2 rst = 1'b1;
        repeat (3) tick();
        check_state("reset");
        check("reset changed", 32'(changed), 0);
        rst = 1'b0;
        repeat (3) tick();

        // Press latency: raw-high from edge N, digit visible after N+DB+3
        c0 = changed_cnt;
        drive(4'b0001);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("latency d1 pre k=%0d", k), 32'(digit_1), 0);
            check($sformatf("latency changed pre k=%0d", k), 32'(changed), 0);
        end
        tick();
        check("latency d1 update", 32'(digit_1), 1);
        check("latency changed high", 32'(changed), 1);
        tick();
        check("latency changed low", 32'(changed), 0);
        repeat (12) tick();                 // keep holding: no repeat
        drive(4'b0000);
        repeat (DB + 6) tick();
        model_press(4'b0001);
        check_state("latency hold");
        check("latency changed count", changed_cnt - c0, 1);

        // Table-driven sequences
        do_press(4'b1000);
        check_state("pre-table clr");
        for (int i = 0; i < tbl.size(); i++) begin
            c0 = changed_cnt;
            press(tbl[i].btns, DB + 2);
            model_press(tbl[i].btns);
            check($sformatf("tbl[%0d] d1", i), 32'(digit_1), tbl[i].exp_d1);
            check($sformatf("tbl[%0d] sel", i), 32'(sel), tbl[i].exp_sel);
            check($sformatf("tbl[%0d] mask", i), 32'(blink_mask), 32'(tbl[i].exp_mask));
            check($sformatf("tbl[%0d] changed", i), changed_cnt - c0, 1);
        end

        // Glitches of DB-1 cycles never get through
        c0 = changed_cnt;
        for (int g = 0; g < 10; g++) begin
            drive(4'b0001);
            repeat (DB - 1) tick();
            drive(4'b0000);
            repeat (DB - 1) tick();
        end
        repeat (DB + 6) tick();
        check_state("glitch");
        check("glitch changed count", changed_cnt - c0, 0);

        // Build 5,3,7,2 with sel=2, then clr+sel+up on one edge
        do_press(4'b1000);
        repeat (5) do_press(4'b0001);
        do_press(4'b0100);
        repeat (3) do_press(4'b0001);
        do_press(4'b0100);
        repeat (7) do_press(4'b0001);
        do_press(4'b0100);
        repeat (2) do_press(4'b0001);
        repeat (3) do_press(4'b0100);
        check("prio setup d1", 32'(digit_1), 5);
        check("prio setup d2", 32'(digit_2), 3);
        check("prio setup d3", 32'(digit_3), 7);
        check("prio setup d4", 32'(digit_4), 2);
        check("prio setup sel", 32'(sel), 2);
        c0 = changed_cnt;
        press(4'b1101, DB + 2);
        model_press(4'b1101);
        check("prio d1", 32'(digit_1), 0);
        check("prio d2", 32'(digit_2), 0);
        check("prio d3", 32'(digit_3), 0);
        check("prio d4", 32'(digit_4), 0);
        check("prio sel", 32'(sel), 0);
        check("prio changed count", changed_cnt - c0, 1);

        // clr on all-zero still pulses changed
        c0 = changed_cnt;
        do_press(4'b1000);
        check("clr on zero changed", changed_cnt - c0, 1);

        // Reset in the middle of a debounce with the button still held
        do_press(4'b0100);
        do_press(4'b0001);
        check_state("pre-rst");
        drive(4'b0001);
        tick();
        tick();
        rst = 1'b1;
        #1;
        model_reset();
        check_state("rst async");
        check("rst async changed", 32'(changed), 0);
        repeat (3) tick();
        rst = 1'b0;
        c0 = changed_cnt;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("post-rst d1 pre k=%0d", k), 32'(digit_1), 0);
        end
        tick();
        check("post-rst d1 update", 32'(digit_1), 1);
        drive(4'b0000);
        repeat (DB + 6) tick();
        model_press(4'b0001);
        check_state("post-rst");
        check("post-rst changed count", changed_cnt - c0, 1);

        // Randomized presses and glitches against the model
        for (int e = 0; e < 60; e++) begin
            c0 = changed_cnt;
            b = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom_range(1, DB - 1);
                drive(b);
                repeat (w) tick();
                drive(4'b0000);
                repeat (DB + 6) tick();
                check_state($sformatf("rnd%0d glitch", e));
                check($sformatf("rnd%0d glitch changed", e), changed_cnt - c0, 0);
            end else begin
                w = $urandom_range(DB + 1, 3 * DB + 4);
                press(b, w);
                model_press(b);
                check_state($sformatf("rnd%0d press b=%0d", e, b));
                check($sformatf("rnd%0d changed", e), changed_cnt - c0, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
